// File: rtl/tick_timer_pkg.sv
// Shared definitions for the multi-channel tick timer: controller state
// encoding used by the top-level FSM.
package tick_timer_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: shadow period and mode, down-counter and registered tick.
// The tick register is computed from the post-edge counter so it lines up with counter==0.
module tick_channel
   import tick_timer_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             advance,
   input  logic             cfg_enable,
   input  logic             cfg_oneshot,
   input  logic [CNT_W-1:0] cfg_period,
   output logic             tick
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] period_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             oneshot_r;
   logic             active_r;
   logic             active_nxt_s;
   logic             tick_r;

   // Counter and activity after one more RUN cycle
   always_comb begin
      cnt_nxt_s    = cnt_r;
      active_nxt_s = active_r;
      if (active_r) begin
         if (cnt_r == CNT_ZERO) begin
            cnt_nxt_s    = period_r - CNT_ONE;
            active_nxt_s = ~oneshot_r;
         end else begin
            cnt_nxt_s    = cnt_r - CNT_ONE;
            active_nxt_s = 1'b1;
         end
      end else begin
         cnt_nxt_s    = cnt_r;
         active_nxt_s = 1'b0;
      end
   end

   // Shadow config, counter and tick register
   always_ff @(posedge clk) begin
      if (reset) begin
         period_r  <= CNT_ZERO;
         oneshot_r <= 1'b0;
         active_r  <= 1'b0;
         cnt_r     <= CNT_ZERO;
         tick_r    <= 1'b0;
      end else if (load) begin
         period_r  <= cfg_period;
         oneshot_r <= cfg_oneshot;
         active_r  <= cfg_enable && (cfg_period != CNT_ZERO);
         cnt_r     <= cfg_period - CNT_ONE;
         tick_r    <= cfg_enable && (cfg_period == CNT_ONE);
      end else if (advance) begin
         cnt_r     <= cnt_nxt_s;
         active_r  <= active_nxt_s;
         tick_r    <= active_nxt_s && (cnt_nxt_s == CNT_ZERO);
      end else begin
         tick_r    <= 1'b0;
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/multi_channel_tick_timer.sv
// Periodic event generator: NUM_CH tick channels, a ch-0 event counter with
// optional auto-terminate, and a saturating elapsed-cycle timestamp.
module multi_channel_tick_timer
   import tick_timer_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   parameter int EVT_W  = 8,
   parameter int TS_W   = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic [NUM_CH-1:0]       ch_enable,
   input  logic [NUM_CH-1:0]       ch_oneshot,
   input  logic [NUM_CH*CNT_W-1:0] period,
   input  logic [EVT_W-1:0]        stop_count,
   output logic [NUM_CH-1:0]       tick,
   output logic [EVT_W-1:0]        event_count,
   output logic [TS_W-1:0]         timestamp,
   output logic                    busy,
   output logic                    done
);

   localparam logic [EVT_W-1:0] EV_ZERO = {EVT_W{1'b0}};
   localparam logic [EVT_W-1:0] EV_ONE  = EVT_W'(1);
   localparam logic [EVT_W-1:0] EV_MAX  = {EVT_W{1'b1}};
   localparam logic [TS_W-1:0]  TS_ZERO = {TS_W{1'b0}};
   localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
   localparam logic [TS_W-1:0]  TS_MAX  = {TS_W{1'b1}};

   state_t            state_r;
   state_t            state_nxt_s;
   logic              load_s;
   logic              advance_s;
   logic              term_s;
   logic [NUM_CH-1:0] tick_s;
   logic [EVT_W-1:0]  stop_r;
   logic [EVT_W-1:0]  ev_r;
   logic [EVT_W-1:0]  ev_inc_s;
   logic [TS_W-1:0]   ts_r;
   logic              busy_r;
   logic              done_r;

   genvar k;
   generate
      for (k = 0; k < NUM_CH; k++) begin : g_ch
         tick_channel #(
            .CNT_W(CNT_W)
         ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .load       (load_s),
            .advance    (advance_s),
            .cfg_enable (ch_enable[k]),
            .cfg_oneshot(ch_oneshot[k]),
            .cfg_period (period[k*CNT_W +: CNT_W]),
            .tick       (tick_s[k])
         );
      end
   endgenerate

   // The ch-0 tick visible now is the one that brings event_count up to stop_count
   assign ev_inc_s = ev_r + EV_ONE;
   assign term_s   = (stop_r != EV_ZERO) && tick_s[0] && (ev_inc_s == stop_r);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; abort takes priority over start everywhere
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (start) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (term_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (start) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Control decode: load on entering RUN, advance while staying in RUN
   always_comb begin
      load_s    = 1'b0;
      advance_s = 1'b0;
      if (state_nxt_s == ST_RUN) begin
         load_s    = (state_r != ST_RUN);
         advance_s = (state_r == ST_RUN);
      end else begin
         load_s    = 1'b0;
         advance_s = 1'b0;
      end
   end

   // Status flags and shadow stop count
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         stop_r <= EV_ZERO;
      end else begin
         busy_r <= (state_nxt_s == ST_RUN);
         done_r <= (state_nxt_s == ST_DONE);
         if (load_s) begin
            stop_r <= stop_count;
         end else begin
            stop_r <= stop_r;
         end
      end
   end

   // Ch-0 event counter, saturating
   always_ff @(posedge clk) begin
      if (reset) begin
         ev_r <= EV_ZERO;
      end else if ((state_nxt_s == ST_IDLE) || load_s) begin
         ev_r <= EV_ZERO;
      end else if ((state_r == ST_RUN) && tick_s[0] && (ev_r != EV_MAX)) begin
         ev_r <= ev_inc_s;
      end else begin
         ev_r <= ev_r;
      end
   end

   // Elapsed RUN cycles, saturating; the first RUN cycle reads 1
   always_ff @(posedge clk) begin
      if (reset) begin
         ts_r <= TS_ZERO;
      end else if (state_nxt_s == ST_IDLE) begin
         ts_r <= TS_ZERO;
      end else if (load_s) begin
         ts_r <= TS_ONE;
      end else if (advance_s && (ts_r != TS_MAX)) begin
         ts_r <= ts_r + TS_ONE;
      end else begin
         ts_r <= ts_r;
      end
   end

   assign tick        = tick_s;
   assign event_count = ev_r;
   assign timestamp   = ts_r;
   assign busy        = busy_r;
   assign done        = done_r;

endmodule

// File: tb/tb_multi_channel_tick_timer.sv
// Scoreboard bench: directed scenarios plus randomized traffic checked every
// cycle against an arithmetic reference model of the tick timer.
module tb_multi_channel_tick_timer;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 16;
   localparam int EVT_W  = 8;
   localparam int TS_W   = 4;
   localparam int TS_MAX = (1 << TS_W) - 1;
   localparam int EV_MAX = (1 << EVT_W) - 1;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    start = 1'b0;
   logic                    abort = 1'b0;
   logic [NUM_CH-1:0]       ch_enable = '0;
   logic [NUM_CH-1:0]       ch_oneshot = '0;
   logic [NUM_CH*CNT_W-1:0] period = '0;
   logic [EVT_W-1:0]        stop_count = '0;
   logic [NUM_CH-1:0]       tick;
   logic [EVT_W-1:0]        event_count;
   logic [TS_W-1:0]         timestamp;
   logic                    busy;
   logic                    done;

   always #5 clk = ~clk;

   multi_channel_tick_timer #(
      .NUM_CH(NUM_CH),
      .CNT_W (CNT_W),
      .EVT_W (EVT_W),
      .TS_W  (TS_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .ch_enable  (ch_enable),
      .ch_oneshot (ch_oneshot),
      .period     (period),
      .stop_count (stop_count),
      .tick       (tick),
      .event_count(event_count),
      .timestamp  (timestamp),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      logic [NUM_CH-1:0] tick;
      int                ev;
      int                ts;
      logic              busy;
      logic              done;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: mode, RUN cycle number and latched configuration
   typedef enum int {M_IDLE, M_RUN, M_DONE} mode_t;
   mode_t             m_mode = M_IDLE;
   int                m_n    = 0;
   int                m_ev   = 0;
   int                m_ts   = 0;
   logic [NUM_CH-1:0] m_tick = '0;
   bit                sh_en[NUM_CH];
   bit                sh_os[NUM_CH];
   int                sh_per[NUM_CH];
   int                sh_stop = 0;

   // Channel k ticks in RUN cycle n when n is a multiple of its period (one-shot: only n == period)
   function automatic logic [NUM_CH-1:0] ticks_at(input int n);
      logic [NUM_CH-1:0] t;
      t = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (sh_en[k] && sh_per[k] != 0) begin
            if (sh_os[k]) t[k] = (n == sh_per[k]);
            else          t[k] = ((n % sh_per[k]) == 0);
         end
      end
      return t;
   endfunction

   task automatic model_edge(input logic r, input logic s, input logic a);
      int ev_new;
      if (r) begin
         m_mode = M_IDLE; m_n = 0; m_ev = 0; m_ts = 0; m_tick = '0; sh_stop = 0;
         for (int k = 0; k < NUM_CH; k++) begin
            sh_en[k] = 1'b0; sh_os[k] = 1'b0; sh_per[k] = 0;
         end
      end else if (a) begin
         m_mode = M_IDLE; m_ev = 0; m_ts = 0; m_tick = '0;
      end else if (s && m_mode != M_RUN) begin
         for (int k = 0; k < NUM_CH; k++) begin
            sh_en[k]  = ch_enable[k];
            sh_os[k]  = ch_oneshot[k];
            sh_per[k] = int'(period[k*CNT_W +: CNT_W]);
         end
         sh_stop = int'(stop_count);
         m_mode = M_RUN; m_n = 1; m_ts = 1; m_ev = 0;
         m_tick = ticks_at(1);
      end else if (m_mode == M_RUN) begin
         ev_new = m_ev;
         if (m_tick[0] && m_ev < EV_MAX) ev_new = m_ev + 1;
         m_ev = ev_new;
         if (sh_stop != 0 && m_tick[0] && ev_new == sh_stop) begin
            m_mode = M_DONE;
            m_tick = '0;
         end else begin
            m_n    = m_n + 1;
            m_ts   = (m_n > TS_MAX) ? TS_MAX : m_n;
            m_tick = ticks_at(m_n);
         end
      end else begin
         m_tick = '0;
      end
   endtask

   // Drive one cycle of control inputs, then record what the DUT must show after the edge
   task automatic step(input logic r, input logic s, input logic a);
      exp_t e;
      @(negedge clk);
      reset = r; start = s; abort = a;
      @(posedge clk);
      #1;
      model_edge(r, s, a);
      e.tick = m_tick;
      e.ev   = m_ev;
      e.ts   = m_ts;
      e.busy = (m_mode == M_RUN);
      e.done = (m_mode == M_DONE);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic set_cfg(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] os,
                          input int p0, input int p1, input int p2, input int p3,
                          input int stop);
      ch_enable  = en;
      ch_oneshot = os;
      period     = {CNT_W'(p3), CNT_W'(p2), CNT_W'(p1), CNT_W'(p0)};
      stop_count = EVT_W'(stop);
   endtask

   task automatic rand_cfg();
      set_cfg(NUM_CH'($urandom), NUM_CH'($urandom),
              $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 9),
              $urandom_range(0, 4));
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Monitor: every cycle the DUT presents a full output set; compare it to the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("tick",        32'(tick),        32'(e.tick));
         check("event_count", 32'(event_count), e.ev);
         check("timestamp",   32'(timestamp),   e.ts);
         check("busy",        32'(busy),        32'(e.busy));
         check("done",        32'(done),        32'(e.done));
      end
   end

   initial begin
      // Reset state
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      idle(2);

      // Periods {1,2,3,5}, periodic, run until abort at t0+20; inputs wiggle mid-run
      set_cfg(4'hF, 4'h0, 1, 2, 3, 5, 0);
      step(1'b0, 1'b1, 1'b0);
      for (int i = 1; i < 20; i++) begin
         if (i == 7) set_cfg(4'h0, 4'hF, 9, 9, 9, 9, 1);
         step(1'b0, 1'b0, 1'b0);
      end
      step(1'b0, 1'b0, 1'b1);
      idle(3);

      // Auto-terminate after three ch-0 events, hold in DONE, then restart from DONE
      set_cfg(4'h1, 4'h0, 4, 0, 0, 0, 3);
      step(1'b0, 1'b1, 1'b0);
      idle(18);
      step(1'b0, 1'b1, 1'b0);
      idle(15);
      step(1'b0, 1'b0, 1'b1);
      idle(2);

      // One-shot ch1, start during RUN ignored, then re-armed via abort + start
      set_cfg(4'h2, 4'h2, 0, 6, 0, 0, 0);
      step(1'b0, 1'b1, 1'b0);
      idle(4);
      step(1'b0, 1'b1, 1'b0);
      idle(10);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      idle(14);
      step(1'b0, 1'b0, 1'b1);

      // ch2 disabled, then ch2 with period 0; period inputs changed mid-run
      set_cfg(4'hB, 4'h0, 2, 3, 3, 4, 0);
      step(1'b0, 1'b1, 1'b0);
      idle(4);
      set_cfg(4'hF, 4'h0, 1, 1, 1, 1, 0);
      idle(8);
      step(1'b0, 1'b0, 1'b1);
      set_cfg(4'hF, 4'h0, 3, 2, 0, 1, 0);
      step(1'b0, 1'b1, 1'b0);
      idle(12);
      step(1'b0, 1'b0, 1'b1);

      // Start and abort together in IDLE
      step(1'b0, 1'b1, 1'b1);
      idle(2);

      // Reset mid-RUN at t0+7, then a 20-cycle run saturating the 4-bit timestamp
      set_cfg(4'hF, 4'h0, 2, 3, 4, 5, 0);
      step(1'b0, 1'b1, 1'b0);
      idle(6);
      step(1'b1, 1'b0, 1'b0);
      idle(2);
      step(1'b0, 1'b1, 1'b0);
      idle(20);
      step(1'b0, 1'b0, 1'b1);

      // Event counter saturation with stop_count = 0
      set_cfg(4'h1, 4'h0, 1, 0, 0, 0, 0);
      step(1'b0, 1'b1, 1'b0);
      idle(262);
      step(1'b0, 1'b0, 1'b1);

      // Randomized traffic
      for (int it = 0; it < 60; it++) begin
         rand_cfg();
         step(1'b0, 1'b1, 1'b0);
         for (int c = 0; c < $urandom_range(10, 50); c++) begin
            if ($urandom_range(0, 3) == 0) rand_cfg();
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 29) == 0);
         end
      end

      idle(2);
      @(negedge clk);
      @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
